// File: rtl/tour_cmd_sequencer_pkg.sv
// Shared constants and types for the Knight tour command sequencer.
// The state enum and the response/opcode encodings live here so RTL and bench agree.
package tour_cmd_sequencer_pkg;

    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [3:0] OP_CAL  = 4'h0;
    localparam logic [3:0] OP_MOVE = 4'h4;
    localparam logic [3:0] OP_TOUR = 4'h6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_SNT  = 3'd3,
        WAIT_RESP = 3'd4
    } seq_state_t;

    // Calibration gets its own, shorter response window.
    function automatic logic is_cal(input logic [15:0] cmd_word);
        return (cmd_word[15:12] == OP_CAL);
    endfunction

endpackage

// File: rtl/tour_cmd_sequencer_if.sv
// Host-queue and RemoteComm handshake bundle for the tour command sequencer.
// slave is the sequencer view; master is the host/transmitter view.
interface tour_cmd_sequencer_if;

    logic        push;
    logic [15:0] push_cmd;
    logic        full;
    logic        empty;
    logic        go;
    logic        abort;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] err_cmd;
    logic        ovfl;

    modport slave (
        input  push, push_cmd, go, abort, cmd_snt, resp_rdy, resp,
        output full, empty, cmd, snd_cmd, busy, done, err, err_cmd, ovfl
    );

    modport master (
        output push, push_cmd, go, abort, cmd_snt, resp_rdy, resp,
        input  full, empty, cmd, snd_cmd, busy, done, err, err_cmd, ovfl
    );

endinterface

// File: rtl/tour_cmd_sequencer_cmd_fifo.sv
// Command FIFO for the sequencer: DEPTH x WIDTH, power-of-two depth, wrapping pointers.
// A push while full is accepted only when a pop happens in the same cycle.
module tour_cmd_sequencer_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_s;
    logic             rd_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == CW'(0));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign rd_s    = pop_i && !empty_o;
    assign wr_s    = push_i && (!full_o || rd_s);

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else if (flush_i) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            if (wr_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_s) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_s) - CW'(rd_s);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (wr_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Issues queued Knight commands to RemoteComm one at a time and waits for each response.
// Acks advance, timeouts re-send up to MAX_RETRY times, NAKs or exhausted retries halt with err.
module tour_cmd_sequencer
    import tour_cmd_sequencer_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [23:0] MOVE_TMO  = 24'hFF_FFFF,
    parameter logic [23:0] CAL_TMO   = 24'h0F_FFFF,
    parameter int          MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    tour_cmd_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t    state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [15:0]   err_cmd_q, err_cmd_d;
    logic [23:0]   timer_q, timer_d;
    logic [23:0]   tmo_q, tmo_d;
    logic [7:0]    retry_q, retry_d;
    logic          err_q, err_d;
    logic          ovfl_q, ovfl_d;
    logic          done_q, done_d;
    logic [15:0]   fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s, fifo_empty_s;
    logic          pop_s, snd_cmd_s, busy_s;
    logic          ack_s, nak_s, tmo_hit_s, retry_ok_s;

    tour_cmd_sequencer_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.abort),
        .push_i  (bus.push),
        .data_i  (bus.push_cmd),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // A response in the timeout cycle takes precedence over the timeout.
    assign ack_s      = bus.resp_rdy && (bus.resp == ACK);
    assign nak_s      = bus.resp_rdy && (bus.resp != ACK);
    assign tmo_hit_s  = !bus.resp_rdy && (timer_q >= tmo_q);
    assign retry_ok_s = (retry_q < 8'(MAX_RETRY));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = (bus.go && (fifo_count_s != CW'(0)) && !err_q) ? LOAD : IDLE;
                LOAD:      state_d = SEND;
                SEND:      state_d = WAIT_SNT;
                WAIT_SNT:  state_d = bus.cmd_snt ? WAIT_RESP : WAIT_SNT;
                WAIT_RESP: begin
                    if (ack_s)                        state_d = fifo_empty_s ? IDLE : LOAD;
                    else if (nak_s)                   state_d = IDLE;
                    else if (tmo_hit_s && retry_ok_s) state_d = SEND;
                    else if (tmo_hit_s)               state_d = IDLE;
                    else                              state_d = WAIT_RESP;
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: command latch, timer, retries and sticky flags.
    always_comb begin
        cmd_d     = cmd_q;
        err_cmd_d = err_cmd_q;
        timer_d   = timer_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        err_d     = err_q;
        done_d    = 1'b0;
        ovfl_d    = ovfl_q | (bus.push & fifo_full_s & ~pop_s);
        if (bus.abort) begin
            err_d  = 1'b0;
            ovfl_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    cmd_d   = fifo_head_s;
                    retry_d = 8'd0;
                    tmo_d   = is_cal(fifo_head_s) ? CAL_TMO : MOVE_TMO;
                end
                WAIT_SNT: begin
                    if (bus.cmd_snt) timer_d = 24'd0;
                    else             timer_d = timer_q;
                end
                WAIT_RESP: begin
                    timer_d = (timer_q == 24'hFF_FFFF) ? timer_q : timer_q + 24'd1;
                    if (ack_s) begin
                        done_d = fifo_empty_s;
                    end else if (nak_s || (tmo_hit_s && !retry_ok_s)) begin
                        err_d     = 1'b1;
                        err_cmd_d = cmd_q;
                    end else if (tmo_hit_s) begin
                        retry_d = retry_q + 8'd1;
                    end else begin
                        retry_d = retry_q;
                    end
                end
                default: begin
                    cmd_d = cmd_q;
                end
            endcase
        end
    end

    // State-decoded outputs; abort suppresses the strobe and the pop in its own cycle.
    always_comb begin
        snd_cmd_s = 1'b0;
        busy_s    = 1'b0;
        pop_s     = 1'b0;
        case (state_q)
            IDLE:      busy_s = 1'b0;
            LOAD:      begin busy_s = 1'b1; pop_s = !bus.abort; end
            SEND:      begin busy_s = 1'b1; snd_cmd_s = !bus.abort; end
            WAIT_SNT:  busy_s = 1'b1;
            WAIT_RESP: busy_s = 1'b1;
            default:   busy_s = 1'b0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= 16'h0000;
            err_cmd_q <= 16'h0000;
            timer_q   <= 24'd0;
            tmo_q     <= 24'd0;
            retry_q   <= 8'd0;
            err_q     <= 1'b0;
            ovfl_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            err_cmd_q <= err_cmd_d;
            timer_q   <= timer_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            ovfl_q    <= ovfl_d;
            done_q    <= done_d;
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.snd_cmd = snd_cmd_s;
    assign bus.busy    = busy_s;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.err_cmd = err_cmd_q;
    assign bus.ovfl    = ovfl_q;
    assign bus.full    = fifo_full_s;
    assign bus.empty   = fifo_empty_s;

endmodule
